// File: rtl/dual_port_memory_responder.sv
// Handshaked fixed-latency main-memory responder: port 0 fetch (read-only), port 1 load/store.
// Optional macro MEM_RESP_ERR_EN adds per-response out-of-range error flags and a store error pulse.

module dpmr_resp_chan #(
  parameter int LATENCY    = 2,
  parameter int RESP_DEPTH = 4,
  parameter int ENT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_acc_i,
  input  logic [ENT_W-1:0] rd_ent_i,
  input  logic             resp_ready_i,
  output logic             req_ready_o,
  output logic             resp_valid_o,
  output logic [ENT_W-1:0] resp_ent_o
);
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic             push_vld;
  logic [ENT_W-1:0] push_ent;
  logic             pop;
  logic [CNT_W-1:0] cred_q, cred_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ENT_W-1:0] fifo_q [RESP_DEPTH];

  // Read pipeline: array sample is taken at the accepting edge, then LATENCY-1 register stages
  if (LATENCY == 1) begin : g_nopipe
    assign push_vld = rd_acc_i;
    assign push_ent = rd_ent_i;
  end else begin : g_pipe
    logic [LATENCY-2:0] vld_q;
    logic [ENT_W-1:0]   ent_q [LATENCY-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= rd_acc_i;
        for (int k = 1; k < LATENCY - 1; k++) vld_q[k] <= vld_q[k-1];
      end
    end

    always_ff @(posedge clk) begin
      ent_q[0] <= rd_ent_i;
      for (int k = 1; k < LATENCY - 1; k++) ent_q[k] <= ent_q[k-1];
    end

    assign push_vld = vld_q[LATENCY-2];
    assign push_ent = ent_q[LATENCY-2];
  end

  // Response FIFO and credit (reads in flight plus queued responses)
  assign resp_valid_o = (fcnt_q != '0);
  assign resp_ent_o   = resp_valid_o ? fifo_q[rd_ptr_q] : '0;
  assign pop          = resp_valid_o & resp_ready_i;
  assign req_ready_o  = (cred_q < CNT_W'(RESP_DEPTH));

  always_comb begin
    cred_d   = cred_q;
    fcnt_d   = fcnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (rd_acc_i && !pop)      cred_d = cred_q + CNT_W'(1);
    else if (!rd_acc_i && pop) cred_d = cred_q - CNT_W'(1);
    if (push_vld && !pop)      fcnt_d = fcnt_q + CNT_W'(1);
    else if (!push_vld && pop) fcnt_d = fcnt_q - CNT_W'(1);
    if (push_vld) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)      rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cred_q   <= '0;
      fcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      cred_q   <= cred_d;
      fcnt_q   <= fcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) fifo_q[wr_ptr_q] <= push_ent;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push_vld && !pop && fcnt_q == CNT_W'(RESP_DEPTH)))
        else $error("dpmr_resp_chan: response FIFO overflow");
    end
  end
`endif
endmodule

module dual_port_memory_responder #(
  parameter int depth      = 2048,
  parameter int LATENCY    = 2,
  parameter int RESP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic [31:0] p0_req_addr,
  output logic        p0_resp_valid,
  input  logic        p0_resp_ready,
  output logic [31:0] p0_resp_data,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic        p1_req_wen,
  input  logic [31:0] p1_req_addr,
  input  logic [31:0] p1_req_wdata,
  output logic        p1_resp_valid,
  input  logic        p1_resp_ready,
  output logic [31:0] p1_resp_data
`ifdef MEM_RESP_ERR_EN
  ,
  output logic        p0_resp_err,
  output logic        p1_resp_err,
  output logic        p1_wr_err
`endif
);
  localparam int IDX_W = $clog2(depth);
`ifdef MEM_RESP_ERR_EN
  localparam int ENT_W = 33;
`else
  localparam int ENT_W = 32;
`endif

  logic [31:0]      mem_q [depth];
  logic             p0_acc, p1_acc, p1_rd_acc;
  logic             p0_oor, p1_oor;
  logic [31:0]      p0_rdata, p1_rdata;
  logic [ENT_W-1:0] p0_ent, p1_ent, p0_head, p1_head;

  assign p0_acc    = p0_req_valid & p0_req_ready;
  assign p1_acc    = p1_req_valid & p1_req_ready;
  assign p1_rd_acc = p1_acc & ~p1_req_wen;
  assign p0_oor    = |p0_req_addr[31:IDX_W];
  assign p1_oor    = |p1_req_addr[31:IDX_W];

  // Both ports sample before the store lands, giving read-before-write on a same-cycle collision
  assign p0_rdata = p0_oor ? 32'h0 : mem_q[p0_req_addr[IDX_W-1:0]];
  assign p1_rdata = p1_oor ? 32'h0 : mem_q[p1_req_addr[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (p1_acc && p1_req_wen && !p1_oor) mem_q[p1_req_addr[IDX_W-1:0]] <= p1_req_wdata;
  end

`ifdef MEM_RESP_ERR_EN
  logic wr_err_q, wr_err_d;

  assign p0_ent      = {p0_oor, p0_rdata};
  assign p1_ent      = {p1_oor, p1_rdata};
  assign p0_resp_err = p0_head[32];
  assign p1_resp_err = p1_head[32];
  assign wr_err_d    = p1_acc & p1_req_wen & p1_oor;
  assign p1_wr_err   = wr_err_q;

  always_ff @(posedge clk) begin
    if (rst) wr_err_q <= 1'b0;
    else     wr_err_q <= wr_err_d;
  end
`else
  assign p0_ent = p0_rdata;
  assign p1_ent = p1_rdata;
`endif

  assign p0_resp_data = p0_head[31:0];
  assign p1_resp_data = p1_head[31:0];

  dpmr_resp_chan #(.LATENCY(LATENCY), .RESP_DEPTH(RESP_DEPTH), .ENT_W(ENT_W)) u_p0 (
    .clk          (clk),
    .rst          (rst),
    .rd_acc_i     (p0_acc),
    .rd_ent_i     (p0_ent),
    .resp_ready_i (p0_resp_ready),
    .req_ready_o  (p0_req_ready),
    .resp_valid_o (p0_resp_valid),
    .resp_ent_o   (p0_head)
  );

  dpmr_resp_chan #(.LATENCY(LATENCY), .RESP_DEPTH(RESP_DEPTH), .ENT_W(ENT_W)) u_p1 (
    .clk          (clk),
    .rst          (rst),
    .rd_acc_i     (p1_rd_acc),
    .rd_ent_i     (p1_ent),
    .resp_ready_i (p1_resp_ready),
    .req_ready_o  (p1_req_ready),
    .resp_valid_o (p1_resp_valid),
    .resp_ent_o   (p1_head)
  );
endmodule

// File: tb/tb_dual_port_memory_responder.sv
// Directed bench for dual_port_memory_responder (depth 2048, LATENCY 2, RESP_DEPTH 4).
// Inputs are driven and outputs sampled on the falling edge.
module tb_dual_port_memory_responder;
  logic        clk;
  logic        rst;
  logic        p0_req_valid, p0_req_ready, p0_resp_valid, p0_resp_ready;
  logic [31:0] p0_req_addr, p0_resp_data;
  logic        p1_req_valid, p1_req_ready, p1_req_wen, p1_resp_valid, p1_resp_ready;
  logic [31:0] p1_req_addr, p1_req_wdata, p1_resp_data;
`ifdef MEM_RESP_ERR_EN
  logic        p0_resp_err, p1_resp_err, p1_wr_err;
`endif

  int checks = 0;
  int errors = 0;
  int n_acc;

  dual_port_memory_responder #(.depth(2048), .LATENCY(2), .RESP_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .p0_req_valid  (p0_req_valid),
    .p0_req_ready  (p0_req_ready),
    .p0_req_addr   (p0_req_addr),
    .p0_resp_valid (p0_resp_valid),
    .p0_resp_ready (p0_resp_ready),
    .p0_resp_data  (p0_resp_data),
    .p1_req_valid  (p1_req_valid),
    .p1_req_ready  (p1_req_ready),
    .p1_req_wen    (p1_req_wen),
    .p1_req_addr   (p1_req_addr),
    .p1_req_wdata  (p1_req_wdata),
    .p1_resp_valid (p1_resp_valid),
    .p1_resp_ready (p1_resp_ready),
    .p1_resp_data  (p1_resp_data)
`ifdef MEM_RESP_ERR_EN
    ,
    .p0_resp_err   (p0_resp_err),
    .p1_resp_err   (p1_resp_err),
    .p1_wr_err     (p1_wr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  initial begin
    rst = 1'b1;
    p0_req_valid = 1'b0; p0_req_addr = '0; p0_resp_ready = 1'b1;
    p1_req_valid = 1'b0; p1_req_wen = 1'b0; p1_req_addr = '0; p1_req_wdata = '0;
    p1_resp_ready = 1'b1;
    cyc(); cyc();

    // reset state
    chk("rst_p0_ready", 32'(p0_req_ready), 32'd1);
    chk("rst_p1_ready", 32'(p1_req_ready), 32'd1);
    chk("rst_p0_valid", 32'(p0_resp_valid), 32'd0);
    chk("rst_p1_valid", 32'(p1_resp_valid), 32'd0);
    chk("rst_p0_data", p0_resp_data, 32'd0);
    chk("rst_p1_data", p1_resp_data, 32'd0);
    rst = 1'b0;

    // preload mem[5] and mem[7] through port 1 stores
    p1_req_valid = 1'b1; p1_req_wen = 1'b1; p1_req_addr = 32'd5; p1_req_wdata = 32'hDEADBEEF;
    cyc();
    p1_req_addr = 32'd7; p1_req_wdata = 32'h0;
    cyc();
    p1_req_valid = 1'b0; p1_req_wen = 1'b0;
    chk("store_no_resp", 32'(p1_resp_valid), 32'd0);
    cyc();

    // fetch latency: accepted in cycle t, visible in t+2 only
    p0_req_valid = 1'b1; p0_req_addr = 32'd5;
    cyc();
    p0_req_valid = 1'b0;
    chk("lat_t1_valid", 32'(p0_resp_valid), 32'd0);
    cyc();
    chk("lat_t2_valid", 32'(p0_resp_valid), 32'd1);
    chk("lat_t2_data", p0_resp_data, 32'hDEADBEEF);
    cyc();
    chk("lat_t3_valid", 32'(p0_resp_valid), 32'd0);
    chk("lat_t3_data", p0_resp_data, 32'd0);

    // same-cycle store/fetch collision, then a load of the new value
    p1_req_valid = 1'b1; p1_req_wen = 1'b1; p1_req_addr = 32'd7; p1_req_wdata = 32'h1234;
    p0_req_valid = 1'b1; p0_req_addr = 32'd7;
    cyc();
    p0_req_valid = 1'b0; p1_req_wen = 1'b0;
    cyc();
    p1_req_valid = 1'b0;
    chk("haz_p0_valid", 32'(p0_resp_valid), 32'd1);
    chk("haz_p0_old", p0_resp_data, 32'd0);
    cyc();
    chk("haz_p1_valid", 32'(p1_resp_valid), 32'd1);
    chk("haz_p1_new", p1_resp_data, 32'h1234);
    cyc();
    chk("haz_p1_drained", 32'(p1_resp_valid), 32'd0);

    // credit limit with the response channel stalled
    p1_resp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      p1_req_valid = 1'b1; p1_req_wen = 1'b0;
      p1_req_addr = (i % 2 == 1) ? 32'd7 : 32'd5;
      chk($sformatf("credit_ready_%0d", i), 32'(p1_req_ready), (i < 4) ? 32'd1 : 32'd0);
      if (p1_req_ready) n_acc++;
      cyc();
    end
    p1_req_valid = 1'b0;
    chk("credit_accepted", 32'(n_acc), 32'd4);
    chk("hold_valid", 32'(p1_resp_valid), 32'd1);
    chk("hold_data", p1_resp_data, 32'hDEADBEEF);
    cyc();
    chk("hold_data_stable", p1_resp_data, 32'hDEADBEEF);
    chk("hold_ready_low", 32'(p1_req_ready), 32'd0);
    p1_resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain_valid_%0d", k), 32'(p1_resp_valid), 32'd1);
      chk($sformatf("drain_data_%0d", k), p1_resp_data, (k % 2 == 1) ? 32'h1234 : 32'hDEADBEEF);
      cyc();
    end
    chk("drain_empty", 32'(p1_resp_valid), 32'd0);
    chk("drain_ready_back", 32'(p1_req_ready), 32'd1);

    // load pattern into 0..15, then stream 16 fetches
    p1_req_valid = 1'b1; p1_req_wen = 1'b1;
    for (int i = 0; i < 16; i++) begin
      p1_req_addr = 32'(i); p1_req_wdata = pat(i);
      cyc();
    end
    p1_req_valid = 1'b0; p1_req_wen = 1'b0;
    for (int j = 0; j < 18; j++) begin
      if (j >= 2) begin
        chk($sformatf("stream_valid_%0d", j), 32'(p0_resp_valid), 32'd1);
        chk($sformatf("stream_data_%0d", j), p0_resp_data, pat(j - 2));
      end else begin
        chk($sformatf("stream_idle_%0d", j), 32'(p0_resp_valid), 32'd0);
      end
      chk($sformatf("stream_ready_%0d", j), 32'(p0_req_ready), 32'd1);
      if (j < 16) begin
        p0_req_valid = 1'b1; p0_req_addr = 32'(j);
      end else begin
        p0_req_valid = 1'b0;
      end
      cyc();
    end
    chk("stream_end", 32'(p0_resp_valid), 32'd0);

    // reset while two loads are in flight
    p1_req_valid = 1'b1; p1_req_wen = 1'b0; p1_req_addr = 32'd5;
    cyc();
    p1_req_addr = 32'd6; rst = 1'b1;
    cyc();
    rst = 1'b0; p1_req_valid = 1'b0;
    chk("rst_mid_ready", 32'(p1_req_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rst_mid_noresp_%0d", i), 32'(p1_resp_valid), 32'd0);
      cyc();
    end

    // out-of-range store is dropped, out-of-range load returns zero
    p1_req_valid = 1'b1; p1_req_wen = 1'b1; p1_req_addr = 32'h805; p1_req_wdata = 32'hBAD;
    cyc();
`ifdef MEM_RESP_ERR_EN
    chk("wr_err_pulse", 32'(p1_wr_err), 32'd1);
`endif
    p1_req_wen = 1'b0; p1_req_addr = 32'd5;
    cyc();
`ifdef MEM_RESP_ERR_EN
    chk("wr_err_clear", 32'(p1_wr_err), 32'd0);
`endif
    p1_req_addr = 32'h900;
    cyc();
    p1_req_valid = 1'b0;
    chk("oor_a_valid", 32'(p1_resp_valid), 32'd1);
    chk("oor_a_data", p1_resp_data, pat(5));
`ifdef MEM_RESP_ERR_EN
    chk("oor_a_err", 32'(p1_resp_err), 32'd0);
`endif
    cyc();
    chk("oor_b_valid", 32'(p1_resp_valid), 32'd1);
    chk("oor_b_data", p1_resp_data, 32'd0);
`ifdef MEM_RESP_ERR_EN
    chk("oor_b_err", 32'(p1_resp_err), 32'd1);
`endif
    cyc();
    chk("oor_done", 32'(p1_resp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dual_port_memory_responder.md
Name: dual_port_memory_responder

Overview:
Responder end of the CPU's main-memory interface. It replaces the zero-latency combinational memory with a handshaked, fixed-latency memory model.
- Port 0 serves instruction fetch (read-only).
- Port 1 serves data loads and stores.
- Each port has a valid/ready request channel and a valid/ready response channel with a per-port response FIFO, so pipelined CPU variants can be verified against realistic memory timing.

Parameters:
depth, 2048, number of 32-bit words in the backing array (power of two)
LATENCY, 2, cycles from request acceptance to response visibility (legal 1..4)
RESP_DEPTH, 4, per-port response FIFO entries; also the per-port outstanding-read limit (legal 2..8)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous, active-high reset
p0_req_valid  input  1  fetch request valid
p0_req_ready  output  1  fetch request accepted this cycle when valid&ready
p0_req_addr  input  32  fetch word address
p0_resp_valid  output  1  fetch response available
p0_resp_ready  input  1  CPU consumes fetch response
p0_resp_data  output  32  fetch read data
p1_req_valid  input  1  data request valid
p1_req_ready  output  1  data request accepted when valid&ready
p1_req_wen  input  1  1=store, 0=load
p1_req_addr  input  32  data word address
p1_req_wdata  input  32  store data
p1_resp_valid  output  1  load response available
p1_resp_ready  input  1  CPU consumes load response
p1_resp_data  output  32  load read data

Behaviour:
- Reset: synchronous, active-high.
  - In-flight pipelines, FIFOs and credit counters are cleared.
  - Memory contents are NOT cleared.
  - Reset values: pX_req_ready=1, pX_resp_valid=0, pX_resp_data=0.
- Reset asserted mid-operation: all in-flight and queued responses are discarded. No response from a pre-reset request ever appears.
- Indexing: word addressed, index = addr[$clog2(depth)-1:0].
  - addr >= depth: a read returns 32'h0; a write is dropped.
- Credit per port: outstanding = reads in latency pipeline + FIFO occupancy.
  - pX_req_ready = (outstanding < RESP_DEPTH).
  - Ready is registered-state only; there is no combinational path from any input.
  - Port 1 ready does not depend on p1_req_wen.
  - Acceptance and FIFO pop in the same cycle: outstanding is unchanged.
- Read timing:
  - Array is sampled at the accepting edge, then held in a LATENCY-1 stage shift pipeline before the FIFO push.
  - Request accepted in cycle t → pX_resp_valid=1 no earlier than cycle t+LATENCY.
  - Back-to-back reads sustain 1/cycle while p*_resp_ready=1.
- Stores:
  - Written at the accepting edge.
  - Produce no response and consume no credit.
- Ordering:
  - Responses on a port return in acceptance order.
  - No ordering is defined between ports.
- Hazards:
  - p1 store and p0 read to the same index in the same cycle: p0 returns the OLD value (read-before-write).
  - p1 store then p1 or p0 read to the same index in a later cycle: returns the NEW value.
- Response FIFO:
  - pX_resp_data is the head entry and is 0 when the FIFO is empty.
  - Pop on resp_valid&resp_ready.
  - Push and pop in the same cycle are legal when full.
  - Overflow is impossible by credit. An overflow attempt fires a simulation-only assertion.
- Response channel: pX_resp_valid, once high, stays high with stable data until popped.

Optional Feature:
- Macro: MEM_RESP_ERR_EN.
- When defined:
  - Adds outputs p0_resp_err and p1_resp_err (1 bit each), carried through the pipeline and FIFO alongside the data.
  - Set for reads with addr >= depth; reset value 0.
  - Adds output p1_wr_err, a 1-cycle pulse on an accepted out-of-range store.
- When undefined: these ports do not exist and out-of-range behaviour is silently as above.

Test Plan:
- Preload mem[5]=32'hDEADBEEF; LATENCY=2; p0 read addr 5 accepted in cycle 10 with p0_resp_ready=1 → p0_resp_valid=1 and data=DEADBEEF in cycle 12 only.
- p1 store addr 7 data 32'h1234 and p0 read addr 7 (old value 0) in the same cycle → p0 returns 0. A p1 load of addr 7 next cycle returns 32'h1234.
- Hold p1_resp_ready=0 and issue 6 loads; RESP_DEPTH=4 → exactly 4 accepted, p1_req_ready=0 from the cycle after the 4th acceptance. Release ready → 4 responses in order, then ready reasserts.
- Stream 16 fetches to addrs 0..15 with p0_resp_ready=1 → 16 consecutive response cycles, data in address order, no bubbles after the first.
- Issue 2 loads, assert rst 1 cycle before the first would return → no p1_resp_valid afterwards; p1_req_ready=1 the cycle after rst deasserts.
- Load addr 32'h900 (depth 2048) → data 0; with MEM_RESP_ERR_EN, p1_resp_err=1 on that response only.
